// File: rtl/defines_riscv.sv
// Shared RISC-V core encodings: load/store size codes as emitted by the decoder.
package defines_riscv;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

endpackage : defines_riscv

// File: rtl/riscv_lsu_pkg.sv
// Load/store unit private types: FSM state encoding and the default bus timeout.
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  localparam int LSU_TIMEOUT_DEFAULT = 16;

endpackage : riscv_lsu_pkg

// File: rtl/riscv_lsu_load_ext.sv
// Load data extraction: picks the addressed byte/halfword out of a memory word
// and sign- or zero-extends it to 32 bits according to the load size.
module riscv_lsu_load_ext
  import defines_riscv::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_offset,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection and extension; purely combinational.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned and infer a latch.
    w_byte = i_word[7:0];
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    o_data = i_word;
    case (i_offset)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    case (i_size)
      LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
      LDST_BU: o_data = {24'h0, w_byte};
      LDST_H:  o_data = {{16{w_half[15]}}, w_half};
      LDST_HU: o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule : riscv_lsu_load_ext

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: accepts one load or store from the core, stalls it
// while a single-beat memory access is in flight, and returns extended load
// data. Misaligned/illegal requests and bus timeouts raise a one-cycle error.
// When a timeout error is reported the core sees stall=0 in that cycle, so a
// still-held request is not silently re-issued before the core reacts.
module riscv_lsu
  import riscv_lsu_pkg::*;
  import defines_riscv::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
)(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_req_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e    r_state;
  lsu_state_e    w_state_nxt;
  logic          r_we;
  logic [2:0]    r_size;
  logic [3:0]    r_be;
  logic [31:0]   r_addr;
  logic [31:0]   r_wd;
  logic [31:0]   r_rd;
  logic [CW-1:0] r_cnt;
  logic          r_tmo_err;

  logic          w_size_ok;
  logic          w_misaligned;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic          w_idle;
  logic          w_busy;
  logic          w_accept;
  logic          w_req_err;
  logic          w_timeout;
  logic [31:0]   w_load_data;

  // Classify the incoming request and precompute its byte enables and store data.
  always_comb begin
    w_size_ok    = 1'b1;
    w_misaligned = 1'b0;
    w_be         = 4'b0000;
    w_wd         = core_wd_i;
    case (core_size_i)
      LDST_B, LDST_BU: begin
        w_be = 4'b0001 << core_addr_i[1:0];
        w_wd = {4{core_wd_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        w_misaligned = core_addr_i[0];
        w_be         = core_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wd         = {2{core_wd_i[15:0]}};
      end
      LDST_W: begin
        w_misaligned = |core_addr_i[1:0];
        w_be         = 4'b1111;
      end
      default: w_size_ok = 1'b0;
    endcase
  end

  assign w_idle    = (r_state == LSU_IDLE);
  assign w_busy    = (r_state == LSU_BUSY);
  assign w_accept  = w_idle & core_req_i & w_size_ok & ~w_misaligned & ~r_tmo_err;
  assign w_req_err = w_idle & core_req_i & (~w_size_ok | w_misaligned);
  assign w_timeout = w_busy & ~mem_ready_i & (r_cnt == CNT_LAST);

  // Next-state selection for the IDLE -> BUSY -> DONE handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LSU_IDLE: if (w_accept) w_state_nxt = LSU_BUSY;
      LSU_BUSY: begin
        if (mem_ready_i)    w_state_nxt = LSU_DONE;
        else if (w_timeout) w_state_nxt = LSU_IDLE;
      end
      LSU_DONE: w_state_nxt = LSU_IDLE;
      default:  w_state_nxt = LSU_IDLE;
    endcase
  end

  riscv_lsu_load_ext u_load_ext (
    .i_word   (mem_rd_i),
    .i_size   (r_size),
    .i_offset (r_addr[1:0]),
    .o_data   (w_load_data)
  );

  // State, captured request fields, timeout counter and returned load data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= LSU_IDLE;
      r_we      <= 1'b0;
      r_size    <= 3'd0;
      r_be      <= 4'b0000;
      r_addr    <= 32'h0;
      r_wd      <= 32'h0;
      r_rd      <= 32'h0;
      r_cnt     <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_state   <= w_state_nxt;
      r_tmo_err <= w_timeout;
      if (w_accept) begin
        r_we   <= core_we_i;
        r_size <= core_size_i;
        r_be   <= w_be;
        r_addr <= core_addr_i;
        r_wd   <= w_wd;
        r_cnt  <= '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_busy && mem_ready_i && !r_we) begin
        r_rd <= w_load_data;
      end
    end
  end

  // Core and memory side outputs; combinational core flags are held low in reset.
  assign core_stall_req_o = rst_i & (w_accept | w_busy);
  assign core_err_o       = rst_i & (w_req_err | r_tmo_err);
  assign core_rd_o        = r_rd;
  assign mem_req_o        = w_busy;
  assign mem_we_o         = r_we;
  assign mem_be_o         = r_be;
  assign mem_addr_o       = {r_addr[31:2], 2'b00};
  assign mem_wd_o         = r_wd;

endmodule : riscv_lsu

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu with hand-computed expectations.
module tb_riscv_lsu;
  import defines_riscv::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [2:0]  core_size_i = 3'd0;
  logic [31:0] core_addr_i = 32'h0;
  logic [31:0] core_wd_i = 32'h0;
  logic [31:0] core_rd_o;
  logic        core_stall_req_o;
  logic        core_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i = 32'h0;
  logic        mem_ready_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  riscv_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .core_req_i       (core_req_i),
    .core_we_i        (core_we_i),
    .core_size_i      (core_size_i),
    .core_addr_i      (core_addr_i),
    .core_wd_i        (core_wd_i),
    .core_rd_o        (core_rd_o),
    .core_stall_req_o (core_stall_req_o),
    .core_err_o       (core_err_o),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .mem_be_o         (mem_be_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wd_o         (mem_wd_o),
    .mem_rd_i         (mem_rd_i),
    .mem_ready_i      (mem_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move to 1ns after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One accepted access: IDLE accept cycle, busy_cycles BUSY cycles (ready in
  // the last), then the DONE cycle. Request stays held through DONE.
  task automatic do_access(input string tag, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int busy_cycles, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_maddr,
                           input logic [31:0] exp_mwd, input logic [31:0] exp_rd);
    int stalls;
    tick();
    core_req_i = 1'b1; core_we_i = we; core_size_i = size;
    core_addr_i = addr; core_wd_i = wd;
    #1;
    check({tag, ".idle_stall"}, 32'(core_stall_req_o), 32'd1);
    check({tag, ".idle_memreq"}, 32'(mem_req_o), 32'd0);
    check({tag, ".idle_err"}, 32'(core_err_o), 32'd0);
    stalls = int'(core_stall_req_o);
    for (int i = 0; i < busy_cycles; i++) begin
      tick();
      if (i == busy_cycles - 1) begin
        mem_ready_i = 1'b1;
        mem_rd_i    = rdata;
      end
      #1;
      check({tag, ".memreq"}, 32'(mem_req_o), 32'd1);
      check({tag, ".we"}, 32'(mem_we_o), 32'(we));
      check({tag, ".be"}, 32'(mem_be_o), 32'(exp_be));
      check({tag, ".addr"}, mem_addr_o, exp_maddr);
      check({tag, ".wd"}, mem_wd_o, exp_mwd);
      stalls += int'(core_stall_req_o);
    end
    tick();
    mem_ready_i = 1'b0;
    mem_rd_i    = 32'h0;
    #1;
    check({tag, ".done_stall"}, 32'(core_stall_req_o), 32'd0);
    check({tag, ".done_memreq"}, 32'(mem_req_o), 32'd0);
    check({tag, ".rd"}, core_rd_o, exp_rd);
    check({tag, ".stall_cycles"}, 32'(stalls), 32'(busy_cycles + 1));
  endtask

  // Rejected request: error pulse in the same cycle, no stall, no access.
  task automatic err_case(input string tag, input logic [2:0] size, input logic [31:0] addr);
    tick();
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = size; core_addr_i = addr;
    #1;
    check({tag, ".err"}, 32'(core_err_o), 32'd1);
    check({tag, ".stall"}, 32'(core_stall_req_o), 32'd0);
    check({tag, ".memreq"}, 32'(mem_req_o), 32'd0);
    tick();
    core_req_i = 1'b0;
    #1;
    check({tag, ".memreq_after"}, 32'(mem_req_o), 32'd0);
    check({tag, ".err_after"}, 32'(core_err_o), 32'd0);
  endtask

  initial begin
    int busy_seen;
    bit found;

    // Reset values, with a legal request presented while in reset.
    #12;
    core_req_i = 1'b1; core_size_i = LDST_W; core_addr_i = 32'h0;
    #1;
    check("rst.rd", core_rd_o, 32'h0);
    check("rst.memreq", 32'(mem_req_o), 32'd0);
    check("rst.stall", 32'(core_stall_req_o), 32'd0);
    check("rst.err", 32'(core_err_o), 32'd0);
    core_req_i = 1'b0;
    #3;
    rst_i = 1'b1;

    // Loads and stores, back to back.
    do_access("lb13",  1'b0, LDST_B,  32'h13, 32'h0,         2, 32'h80FF_7F01, 4'b1000, 32'h10, 32'h0,         32'hFFFF_FF80);
    do_access("sh22",  1'b1, LDST_H,  32'h22, 32'h1234_ABCD, 1, 32'h5555_5555, 4'b1100, 32'h20, 32'hABCD_ABCD, 32'hFFFF_FF80);
    do_access("lhu02", 1'b0, LDST_HU, 32'h02, 32'h0,         1, 32'hF00D_0000, 4'b1100, 32'h00, 32'h0,         32'h0000_F00D);
    do_access("sw40",  1'b1, LDST_W,  32'h40, 32'hDEAD_BEEF, 3, 32'h1111_1111, 4'b1111, 32'h40, 32'hDEAD_BEEF, 32'h0000_F00D);
    do_access("sb01",  1'b1, LDST_B,  32'h01, 32'h0000_00A5, 1, 32'h0,         4'b0010, 32'h00, 32'hA5A5_A5A5, 32'h0000_F00D);
    do_access("lh00",  1'b0, LDST_H,  32'h00, 32'h0,         1, 32'h0000_8001, 4'b0011, 32'h00, 32'h0,         32'hFFFF_8001);
    do_access("lbu01", 1'b0, LDST_BU, 32'h01, 32'h0,         2, 32'h1234_8800, 4'b0010, 32'h00, 32'h0,         32'h0000_0088);
    do_access("lw44",  1'b0, LDST_W,  32'h44, 32'h0,         1, 32'hCAFE_F00D, 4'b1111, 32'h44, 32'h0,         32'hCAFE_F00D);
    tick();
    core_req_i = 1'b0;

    // Misaligned and illegal-size requests.
    err_case("lw06", LDST_W, 32'h06);
    err_case("lh03", LDST_H, 32'h03);
    err_case("sz3", 3'd3, 32'h0);
    err_case("sz7", 3'd7, 32'h0);

    // A ready pulse while idle must not touch the load register.
    tick();
    mem_ready_i = 1'b1; mem_rd_i = 32'hFFFF_FFFF;
    tick();
    mem_ready_i = 1'b0; mem_rd_i = 32'h0;
    #1;
    check("stray_ready.rd", core_rd_o, 32'hCAFE_F00D);
    check("stray_ready.memreq", 32'(mem_req_o), 32'd0);

    // Timeout: no ready for 16 BUSY cycles.
    tick();
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LDST_W; core_addr_i = 32'h08;
    busy_seen = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      #1;
      if (core_err_o) begin
        found = 1'b1;
        break;
      end
      busy_seen += int'(mem_req_o);
    end
    check("tmo.err_seen", 32'(found), 32'd1);
    check("tmo.busy_cycles", 32'(busy_seen), 32'd16);
    check("tmo.memreq", 32'(mem_req_o), 32'd0);
    check("tmo.stall", 32'(core_stall_req_o), 32'd0);
    check("tmo.rd", core_rd_o, 32'hCAFE_F00D);
    tick();
    core_req_i = 1'b0;
    #1;
    check("tmo.err_after", 32'(core_err_o), 32'd0);
    check("tmo.memreq_after", 32'(mem_req_o), 32'd0);

    // Reset in the middle of a BUSY access.
    tick();
    core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = LDST_W;
    core_addr_i = 32'h10; core_wd_i = 32'h0000_0001;
    tick();
    #1;
    check("rstbusy.memreq_before", 32'(mem_req_o), 32'd1);
    #1;
    rst_i = 1'b0;
    #1;
    check("rstbusy.memreq", 32'(mem_req_o), 32'd0);
    check("rstbusy.stall", 32'(core_stall_req_o), 32'd0);
    check("rstbusy.err", 32'(core_err_o), 32'd0);
    check("rstbusy.rd", core_rd_o, 32'h0);
    core_req_i = 1'b0;
    #3;
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check("rstbusy.no_replay", 32'(mem_req_o), 32'd0);
      check("rstbusy.no_stall", 32'(core_stall_req_o), 32'd0);
    end
    do_access("lbu03", 1'b0, LDST_BU, 32'h03, 32'h0, 1, 32'h7F00_0000, 4'b1000, 32'h00, 32'h0, 32'h0000_007F);
    tick();
    core_req_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_riscv_lsu

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: BUSY cycles without mem_ready_i before abort.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 core_req_i  input  1  load/store request from decoder (mem_req); held by core while stalled.
REQ-005 core_we_i  input  1  1 = store, 0 = load.
REQ-006 core_size_i  input  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5 (defines_riscv encoding).
REQ-007 core_addr_i  input  32  byte address (ALU result).
REQ-008 core_wd_i  input  32  store data (rs2).
REQ-009 core_rd_o  output  32  extended load data.
REQ-010 core_stall_req_o  output  1  1 = core must hold PC/en_i low.
REQ-011 core_err_o  output  1  one-cycle pulse: misaligned, illegal size or timeout.
REQ-012 mem_req_o  output  1  memory access request.
REQ-013 mem_we_o  output  1  memory write enable.
REQ-014 mem_be_o  output  4  byte enables.
REQ-015 mem_addr_o  output  32  word address, {addr[31:2],2'b00}.
REQ-016 mem_wd_o  output  32  lane-replicated store data.
REQ-017 mem_rd_i  input  32  memory read word, valid when mem_ready_i=1.
REQ-018 mem_ready_i  input  1  access complete, one-cycle pulse.

Function
REQ-019 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-020 IDLE, core_req_i=1, legal and aligned: capture we/size/addr[1:0]/be/addr/wd into registers, go BUSY.
REQ-021 IDLE, core_req_i=1, misaligned (H/HU addr[0]=1; W addr[1:0]!=0) or size in {3,6,7}: core_err_o=1 same cycle, no stall, no memory access, stay IDLE.
REQ-022 BUSY: mem_req_o=1; mem_we_o, mem_be_o, mem_addr_o, mem_wd_o from registers, stable until mem_ready_i.
REQ-023 BUSY, mem_ready_i=1: load extraction of mem_rd_i registered into core_rd_o, go DONE; mem_req_o drops next cycle.
REQ-024 DONE: core_stall_req_o=0 for exactly one cycle, core_rd_o valid; unconditionally go IDLE.
REQ-025 core_stall_req_o = core_req_i & legal & aligned in IDLE; 1 in BUSY; 0 in DONE.
REQ-026 Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU addr[1]?4'b1100:4'b0011; W 4'b1111; loads drive same be.
REQ-027 Store data: SB {4{wd[7:0]}}, SH {2{wd[15:0]}}, SW wd.
REQ-028 Load: B/BU select byte addr[1:0], H/HU halfword addr[1]; B/H sign-extend, BU/HU zero-extend.
REQ-029 Timeout counter clears on BUSY entry, increments per BUSY cycle; at TIMEOUT_CYCLES with no ready: core_err_o pulse, mem_req_o=0, go IDLE, core_rd_o unchanged.
REQ-030 mem_ready_i outside BUSY ignored.
REQ-031 core_rd_o holds last load value until next completed load; stores never modify it.
REQ-032 mem_req_o=0 in IDLE and DONE; exactly one mem_req_o burst per accepted request.

Reset
REQ-033 rst_i=0 asynchronously forces IDLE, counter 0, core_rd_o=0, all registered request fields 0; mem_req_o, core_stall_req_o, core_err_o=0.
REQ-034 Reset during BUSY aborts access without error pulse; request is not replayed.

Structure
REQ-035 riscv_lsu_pkg holds FSM state enum and default TIMEOUT_CYCLES; size codes stay in defines_riscv.
REQ-036 One combinational sub-module riscv_lsu_load_ext: (word, size, offset) -> extended 32-bit data.

Verification
REQ-037 LB addr 0x13, mem_rd_i 0x80FF_7F01, ready after 2 BUSY cycles -> be 4'b1000, mem_addr 0x10, core_rd_o 0xFFFF_FF80, stall 3 cycles then 0.
REQ-038 SH addr 0x22, wd 0x1234_ABCD -> mem_we 1, be 4'b1100, mem_wd 0xABCD_ABCD, mem_addr 0x20.
REQ-039 LW addr 0x06 -> core_err_o pulse, stall 0, mem_req_o never 1.
REQ-040 LHU addr 0x02, mem_rd_i 0xF00D_0000 -> core_rd_o 0x0000_F00D; back-to-back SW next cycle after DONE accepted.
REQ-041 No mem_ready_i for 16 BUSY cycles -> core_err_o pulse, IDLE, core_rd_o unchanged.
REQ-042 rst_i low mid-BUSY -> mem_req_o, stall 0 immediately; after release, no access until new core_req_i.
